// File: rtl/data_sram_responder_if.sv
// Request/response bundle between the execute-stage data port and its memory responder.
interface data_sram_responder_if;
    logic        data_sram_en;
    logic [3:0]  data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [1:0]  data_sram_size;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    modport master (
        output data_sram_en,
        output data_sram_we,
        output data_sram_addr,
        output data_sram_wdata,
        output data_sram_size,
        input  data_sram_addr_ok,
        input  data_sram_data_ok,
        input  data_sram_rdata
    );

    modport slave (
        input  data_sram_en,
        input  data_sram_we,
        input  data_sram_addr,
        input  data_sram_wdata,
        input  data_sram_size,
        output data_sram_addr_ok,
        output data_sram_data_ok,
        output data_sram_rdata
    );
endinterface

// File: rtl/data_sram_responder.sv
// Data-side SRAM-like responder: word RAM written through byte strobes, with
// read data returned in order through a fixed-latency response queue.
module data_sram_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2,
    parameter int QDEPTH  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    data_sram_responder_if.slave bus,
    input  logic                 addr_stall,
    output logic                 misalign_err
);
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);

    logic [31:0]       mem [2**ADDR_W];

    logic [31:0]       entryData_q [QDEPTH];
    logic [3:0]        entryCnt_q  [QDEPTH];
    logic [QDEPTH-1:0] entryVld_q;
    logic [PW-1:0]     head_q;
    logic [PW-1:0]     tail_q;
    logic [CW-1:0]     occ_q;
    logic [CW-1:0]     occ_d;
    logic              misalign_q;
    logic              misalign_d;

    logic [ADDR_W-1:0] wordIdx;
    logic [3:0]        strobe;
    logic              misaligned;
    logic              isWrite;
    logic              pop;
    logic              push;
    logic              addrOk;
    logic              unusedAddrBits;

    function automatic logic [PW-1:0] wrapInc(input logic [PW-1:0] p);
        return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign wordIdx        = bus.data_sram_addr[ADDR_W+1:2];
    assign unusedAddrBits = ^bus.data_sram_addr[31:ADDR_W+2];
    assign isWrite        = |bus.data_sram_we;

    // A full queue can still accept when its head leaves on the same edge.
    assign pop    = entryVld_q[head_q] && (entryCnt_q[head_q] == 4'd0);
    assign addrOk = reset && !addr_stall && ((occ_q < CW'(QDEPTH)) || pop);
    assign push   = bus.data_sram_en && addrOk;

    always_comb begin
        strobe     = 4'b0000;
        misaligned = 1'b0;
        case (bus.data_sram_size)
            2'b00: strobe = 4'b0001 << bus.data_sram_addr[1:0];
            2'b01: begin
                strobe     = bus.data_sram_addr[1] ? 4'b1100 : 4'b0011;
                misaligned = bus.data_sram_addr[0];
            end
            2'b10: begin
                strobe     = 4'b1111;
                misaligned = (bus.data_sram_addr[1:0] != 2'b00);
            end
            default: misaligned = 1'b1;
        endcase
    end

    always_comb begin
        occ_d = occ_q;
        if (push && !pop) begin
            occ_d = occ_q + 1'b1;
        end else if (pop && !push) begin
            occ_d = occ_q - 1'b1;
        end
        misalign_d = misalign_q | (push & misaligned);
    end

    // RAM has no reset; misaligned writes are acknowledged but dropped.
    always_ff @(posedge clk) begin
        if (push && isWrite && !misaligned) begin
            for (int b = 0; b < 4; b++) begin
                if (strobe[b]) begin
                    mem[wordIdx][8*b +: 8] <= bus.data_sram_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < QDEPTH; i++) begin
                entryData_q[i] <= '0;
                entryCnt_q[i]  <= '0;
            end
            entryVld_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            occ_q      <= '0;
            misalign_q <= 1'b0;
        end else begin
            for (int i = 0; i < QDEPTH; i++) begin
                if (entryVld_q[i] && (entryCnt_q[i] != 4'd0)) begin
                    entryCnt_q[i] <= entryCnt_q[i] - 4'd1;
                end
            end
            if (pop) begin
                entryVld_q[head_q] <= 1'b0;
                head_q             <= wrapInc(head_q);
            end
            // Pushed last so a same-slot push wins over the pop when full.
            if (push) begin
                entryVld_q[tail_q]  <= 1'b1;
                entryCnt_q[tail_q]  <= 4'(LATENCY - 1);
                entryData_q[tail_q] <= isWrite ? 32'h0 : mem[wordIdx];
                tail_q              <= wrapInc(tail_q);
            end
            occ_q      <= occ_d;
            misalign_q <= misalign_d;
        end
    end

    assign bus.data_sram_addr_ok = addrOk;
    assign bus.data_sram_data_ok = pop;
    assign bus.data_sram_rdata   = pop ? entryData_q[head_q] : 32'h0;
    assign misalign_err          = misalign_q;
endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: directed scenarios plus random traffic, all
// compared every cycle against a queue-based model of the response timeline.
module tb_data_sram_responder;
    localparam int LAT = 2;
    localparam int QD  = 2;
    localparam int AW  = 10;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic addrStall = 1'b0;
    logic misalignErr;

    data_sram_responder_if bus();

    data_sram_responder #(.ADDR_W(AW), .LATENCY(LAT), .QDEPTH(QD)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .addr_stall   (addrStall),
        .misalign_err (misalignErr)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nFails  = 0;
    int cycNo   = 0;
    int edgeNo  = 0;

    typedef struct {
        logic [31:0] rd;
        int          due;
    } entry_t;

    entry_t      mq[$];
    logic [31:0] mmem [1024];
    bit          mmis = 1'b0;
    logic [31:0] respLog[$];
    int          respCyc[$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic bit expDataOk();
        return reset && (mq.size() > 0) && (mq[0].due == edgeNo);
    endfunction

    function automatic bit expAddrOk();
        return reset && !addrStall && ((mq.size() < QD) || expDataOk());
    endfunction

    function automatic bit laneHit(input int b, input logic [31:0] a, input logic [1:0] s);
        case (s)
            2'd0:    return b == int'(a % 4);
            2'd1:    return (b / 2) == int'((a / 2) % 2);
            default: return 1'b1;
        endcase
    endfunction

    task automatic modelAccept();
        int          idx;
        bit          mis;
        logic [31:0] a;
        logic [1:0]  s;
        logic [31:0] r;
        a   = bus.data_sram_addr;
        s   = bus.data_sram_size;
        idx = int'((a / 4) % 1024);
        mis = (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && (a % 4) != 0);
        if (mis) mmis = 1'b1;
        r = 32'h0;
        if (bus.data_sram_we != 4'h0) begin
            if (!mis) begin
                for (int b = 0; b < 4; b++) begin
                    if (laneHit(b, a, s)) mmem[idx][8*b +: 8] = bus.data_sram_wdata[8*b +: 8];
                end
            end
        end else begin
            r = mmem[idx];
        end
        mq.push_back('{rd: r, due: edgeNo + LAT - 1});
    endtask

    always @(posedge clk) cycNo++;

    // Model advances on each edge: the head leaves when due, one request may join.
    always @(posedge clk or negedge reset) begin
        bit popNow;
        bit accNow;
        if (!reset) begin
            mq.delete();
            mmis = 1'b0;
        end else begin
            popNow = expDataOk();
            accNow = bus.data_sram_en && expAddrOk();
            edgeNo++;
            if (popNow) void'(mq.pop_front());
            if (accNow) modelAccept();
        end
    end

    // Every cycle, mid-period, the DUT outputs must match the model.
    always @(negedge clk) begin
        bit eOk;
        eOk = expDataOk();
        checkOutput("addr_ok", {31'h0, bus.data_sram_addr_ok}, {31'h0, expAddrOk()});
        checkOutput("data_ok", {31'h0, bus.data_sram_data_ok}, {31'h0, eOk});
        checkOutput("rdata", bus.data_sram_rdata, eOk ? mq[0].rd : 32'h0);
        checkOutput("misalign_err", {31'h0, misalignErr}, {31'h0, mmis});
        if (bus.data_sram_data_ok) begin
            respLog.push_back(bus.data_sram_rdata);
            respCyc.push_back(cycNo);
        end
    end

    task automatic applyStimulus(input logic [3:0] we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [1:0] size);
        bit ok;
        int n;
        n = 0;
        bus.data_sram_en    = 1'b1;
        bus.data_sram_we    = we;
        bus.data_sram_addr  = addr;
        bus.data_sram_wdata = wdata;
        bus.data_sram_size  = size;
        do begin
            @(negedge clk);
            ok = bus.data_sram_addr_ok;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 20);
        if (!ok) checkOutput("accept_timeout", 32'h0, 32'h1);
        bus.data_sram_en = 1'b0;
    endtask

    task automatic waitResponses(input int target);
        int n;
        n = 0;
        while (respLog.size() < target && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("resp_count", 32'(respLog.size()), 32'(target));
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int logSize;
        logic [31:0] a;
        bus.data_sram_en    = 1'b0;
        bus.data_sram_we    = 4'h0;
        bus.data_sram_addr  = 32'h0;
        bus.data_sram_wdata = 32'h0;
        bus.data_sram_size  = 2'b10;

        repeat (3) begin
            @(negedge clk);
            checkOutput("reset_addr_ok", {31'h0, bus.data_sram_addr_ok}, 32'h0);
            checkOutput("reset_data_ok", {31'h0, bus.data_sram_data_ok}, 32'h0);
            checkOutput("reset_rdata", bus.data_sram_rdata, 32'h0);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        checkOutput("idle_addr_ok", {31'h0, bus.data_sram_addr_ok}, 32'h1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("idle_no_resp", 32'(respLog.size()), 32'h0);

        // Word write then read back.
        applyStimulus(4'hF, 32'h40, 32'hDEADBEEF, 2'b10);
        applyStimulus(4'h0, 32'h40, 32'h0, 2'b10);
        waitResponses(2);
        checkOutput("wr_resp_rdata", respLog[0], 32'h0);
        checkOutput("rd_resp_rdata", respLog[1], 32'hDEADBEEF);

        // Byte and half merges into an existing word.
        base = respLog.size();
        applyStimulus(4'hF, 32'h40, 32'h11223344, 2'b10);
        applyStimulus(4'h1, 32'h41, 32'h5A5A5A5A, 2'b00);
        applyStimulus(4'h0, 32'h40, 32'h0, 2'b10);
        applyStimulus(4'h3, 32'h42, 32'hBEEFBEEF, 2'b01);
        applyStimulus(4'h0, 32'h40, 32'h0, 2'b10);
        waitResponses(base + 5);
        checkOutput("byte_merge", respLog[base+2], 32'h11225A44);
        checkOutput("half_merge", respLog[base+4], 32'hBEEF5A44);

        // Fill words 0..7, then stream back-to-back reads.
        for (int i = 0; i < 8; i++) applyStimulus(4'hF, 32'(i * 4), 32'hA0000000 + 32'(i) * 32'h111, 2'b10);
        base = respLog.size();
        waitResponses(base);
        repeat (4) @(posedge clk);
        #1;
        base = respLog.size();
        for (int i = 0; i < 8; i++) begin
            bus.data_sram_en    = 1'b1;
            bus.data_sram_we    = 4'h0;
            bus.data_sram_addr  = 32'(i * 4);
            bus.data_sram_size  = 2'b10;
            @(negedge clk);
            checkOutput("b2b_addr_ok", {31'h0, bus.data_sram_addr_ok}, 32'h1);
            @(posedge clk);
            #1;
        end
        bus.data_sram_en = 1'b0;
        waitResponses(base + 8);
        for (int i = 0; i < 8; i++) begin
            checkOutput("b2b_rdata", respLog[base+i], 32'hA0000000 + 32'(i) * 32'h111);
            checkOutput("b2b_consecutive", 32'(respCyc[base+i]), 32'(respCyc[base] + i));
        end

        // Stall: no accept while addr_stall is high.
        logSize = respLog.size();
        bus.data_sram_en   = 1'b1;
        bus.data_sram_we   = 4'h0;
        bus.data_sram_addr = 32'h40;
        addrStall          = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("stall_addr_ok", {31'h0, bus.data_sram_addr_ok}, 32'h0);
            @(posedge clk);
            #1;
        end
        bus.data_sram_en = 1'b0;
        addrStall        = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("stall_no_resp", 32'(respLog.size()), 32'(logSize));

        // Misaligned half read and misaligned word write.
        checkOutput("mis_before", {31'h0, misalignErr}, 32'h0);
        base = respLog.size();
        applyStimulus(4'h0, 32'h43, 32'h0, 2'b01);
        waitResponses(base + 1);
        checkOutput("mis_set", {31'h0, misalignErr}, 32'h1);
        applyStimulus(4'hF, 32'h41, 32'h12345678, 2'b10);
        applyStimulus(4'h0, 32'h40, 32'h0, 2'b10);
        waitResponses(base + 3);
        checkOutput("mis_no_write", respLog[base+2], 32'hBEEF5A44);
        checkOutput("mis_sticky", {31'h0, misalignErr}, 32'h1);

        // Reset with two requests in flight discards both responses.
        applyStimulus(4'h0, 32'h0, 32'h0, 2'b10);
        applyStimulus(4'h0, 32'h4, 32'h0, 2'b10);
        reset   = 1'b0;
        logSize = respLog.size();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checkOutput("reset_discard", 32'(respLog.size()), 32'(logSize));
        checkOutput("mis_cleared", {31'h0, misalignErr}, 32'h0);

        // Random traffic over words 0..7 with aliasing upper address bits.
        for (int i = 0; i < 400; i++) begin
            a = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 7) << 2) | 32'($urandom_range(0, 3));
            bus.data_sram_en    = ($urandom_range(0, 3) != 0);
            bus.data_sram_we    = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            bus.data_sram_addr  = a;
            bus.data_sram_wdata = $urandom;
            bus.data_sram_size  = 2'($urandom_range(0, 3));
            addrStall           = ($urandom_range(0, 4) == 0);
            @(posedge clk);
            #1;
        end
        bus.data_sram_en = 1'b0;
        addrStall        = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("drained", 32'(mq.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
